// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shift unit, one bit of shift per clock.
// A command (din, shamt, LR, AL) is taken over a valid/ready handshake while
// idle. The operand is then shifted one position per edge, and the result is
// offered on dout with out_valid until the consumer takes it.
//
// Optional build macro ITER_SHIFTER_ROTL_EN: when defined, LR=1/AL=1 rotates
// left instead of shifting left. Right shifts are the same in both builds.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a command, in_ready=1
// S_SHIFT | shifting one bit per edge until count runs out
// S_DONE  | result on dout with out_valid=1, held until out_ready

module iter_shifter #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   shamt,
    input  logic             LR,
    input  logic             AL,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   count;
    logic             lr_q;
    logic             al_q;
    logic [WIDTH-1:0] step_data;

    // Value of the data register after one more shift step
    always_comb begin
        step_data = data;
        if (lr_q) begin
`ifdef ITER_SHIFTER_ROTL_EN
            // Rotate-left recycles the outgoing MSB into the LSB
            step_data = {data[WIDTH-2:0], (al_q ? data[WIDTH-1] : 1'b0)};
`else
            step_data = {data[WIDTH-2:0], 1'b0};
`endif
        end else begin
            step_data = {(al_q ? data[WIDTH-1] : 1'b0), data[WIDTH-1:1]};
        end
    end

    // Control FSM, datapath registers and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            data      <= '0;
            count     <= '0;
            lr_q      <= 1'b0;
            al_q      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        data     <= din;
                        lr_q     <= LR;
                        al_q     <= AL;
                        count    <= shamt;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (shamt == '0) begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    data  <= step_data;
                    count <= count - SHW'(1);
                    if (count == SHW'(1)) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // dout always shows the data register; only meaningful with out_valid
    assign dout = data;

endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: directed and random commands for iter_shifter, checked
// against an arithmetic reference of the shift/rotate rules.

module tb_iter_shifter;

    localparam int W   = 8;
    localparam int SHW = 3;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   din;
    logic [SHW-1:0] shamt;
    logic           LR;
    logic           AL;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   dout;
    logic           busy;

    int checks = 0;
    int errors = 0;

    iter_shifter #(.WIDTH(W), .SHW(SHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .shamt     (shamt),
        .LR        (LR),
        .AL        (AL),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: shift result computed with plain integer arithmetic
    function automatic int ref_shift(input int d, input int sh, input bit lr, input bit al);
        int s;
        if (lr) begin
`ifdef ITER_SHIFTER_ROTL_EN
            if (al) return ((d << sh) | (d >> (W - sh))) & ((1 << W) - 1);
`endif
            return (d << sh) & ((1 << W) - 1);
        end
        if (al) begin
            s = (d >= (1 << (W - 1))) ? d - (1 << W) : d;
            return (s >>> sh) & ((1 << W) - 1);
        end
        return d >> sh;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, check latency/result, apply hold cycles of backpressure
    task automatic run_cmd(input int d, input int sh, input bit lr, input bit al, input int hold);
        int exp;
        int edges;
        logic [W-1:0] held;
        exp = ref_shift(d, sh, lr, al);
        check("idle_in_ready", in_ready, 1);
        in_valid = 1'b1;
        din      = W'(d);
        shamt    = SHW'(sh);
        LR       = lr;
        AL       = al;
        tick();
        // Scramble inputs: must have no effect after the accept edge
        in_valid = 1'b1;
        din      = W'($urandom);
        shamt    = SHW'($urandom);
        LR       = 1'($urandom);
        AL       = 1'($urandom);
        edges = 0;
        while (!out_valid && edges < 40) begin
            check("busy_in_shift", {busy, in_ready}, 2'b10);
            tick();
            edges++;
        end
        check("latency", edges, sh);
        check("out_valid", out_valid, 1);
        check("result", dout, exp);
        held = dout;
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            din       = W'($urandom);
            shamt     = SHW'($urandom);
            tick();
            check("hold_dout", dout, held);
            check("hold_flags", {out_valid, in_ready, busy}, 3'b101);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("after_handshake", {out_valid, in_ready, busy}, 3'b010);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; din = '0; shamt = '0;
        LR = 1'b0; AL = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_flags", {in_ready, out_valid, busy}, 3'b100);
        check("rst_dout", dout, 0);
        rst_n = 1'b1;
        tick();
        // out_ready while idle is ignored
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_out_ready_ignored", {in_ready, out_valid}, 2'b10);

        run_cmd('h96, 3, 1, 0, 0);
        check("case1_value", dout, 'hB0);
        run_cmd('h96, 2, 0, 0, 0);
        run_cmd('h96, 5, 0, 1, 0);
        run_cmd('h76, 7, 0, 1, 0);
        run_cmd('h96, 0, 1, 1, 0);
        run_cmd('h96, 0, 0, 1, 0);
        run_cmd('h96, 3, 1, 0, 4);
        run_cmd('h96, 3, 1, 1, 1);
        run_cmd('hFF, 7, 1, 0, 0);
        run_cmd('h01, 7, 1, 1, 0);

        // Reset during SHIFT discards the operation
        in_valid = 1'b1; din = 8'h80; shamt = 3'd7; LR = 1'b0; AL = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_flags", {in_ready, out_valid, busy}, 3'b100);
        check("midrst_dout", dout, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("midrst_no_valid", out_valid, 0);
        end
        run_cmd('h80, 7, 0, 1, 0);

        // Random commands
        for (int n = 0; n < 40; n++) begin
            run_cmd(int'($urandom_range(255, 0)), int'($urandom_range(7, 0)),
                    1'($urandom), 1'($urandom), int'($urandom_range(2, 0)));
            for (int i = 0; i < int'($urandom_range(2, 0)); i++) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
Multi-cycle sequential shift unit: the iterative counterpart of the single-cycle combinational barrel shifter.
- Accepts a shift command over a valid/ready input handshake.
- Shifts the latched operand one bit per clock.
- Returns the result over a valid/ready output handshake.
- Used where area matters more than latency; supports the same command encoding (shamt, LR, AL) as the combinational shifter.

Parameters:
WIDTH, 8, operand/result width in bits (must be a power of two, >=2)
SHW, 3, shift-amount width; equals log2(WIDTH)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  command present on din/shamt/LR/AL
in_ready  output  1  unit can accept a command (high only in IDLE)
din  input  WIDTH  operand
shamt  input  SHW  shift amount, 0..WIDTH-1
LR  input  1  1 = left shift, 0 = right shift
AL  input  1  1 = arithmetic, 0 = logical (affects right shifts only, see Optional Feature)
out_valid  output  1  result available on dout
out_ready  input  1  consumer takes result
dout  output  WIDTH  shift result, held stable while out_valid=1
busy  output  1  high in SHIFT or DONE

Behaviour:
- One clock (clk). Reset is synchronous, active-low (rst_n), sampled on the rising edge of clk.
- Reset values:
  - State = IDLE; data register, count, LR/AL latches = 0.
  - Outputs: in_ready=1, out_valid=0, busy=0, dout=0.
- States:
  - IDLE: in_ready=1.
    - On in_valid && in_ready, latch din, LR and AL; load count=shamt.
    - Next state: shamt==0 -> DONE; otherwise -> SHIFT.
  - SHIFT: each edge shifts the data register by exactly one bit and decrements count.
    - When count==1 at the edge, next state is DONE.
    - Left shift: shift in 0 at the LSB.
    - Right logical: shift in 0 at the MSB.
    - Right arithmetic: replicate the current MSB.
  - DONE: out_valid=1; dout = data register.
    - On out_valid && out_ready, next state is IDLE.
- Latency: with the command accepted at edge T, out_valid is high in the cycle after edge T+max(shamt,0).
  - shamt=0: DONE immediately after the accept edge (1 cycle).
  - shamt=k: DONE after k further edges.
- Backpressure: DONE holds indefinitely while out_ready=0; dout must not change.
- No overlap between commands.
  - in_ready=0 in SHIFT and DONE; in_valid is ignored there.
  - in_ready returns to 1 in the cycle after the output handshake.
- Inputs din/shamt/LR/AL are sampled only at the accept edge; later changes have no effect.
- out_ready while out_valid=0 is ignored.
- Reset mid-operation (rst_n=0 at any edge in SHIFT/DONE): the operation is discarded, all reset values apply at that edge, and no out_valid pulse is produced.
- dout is driven from the data register in all states and may show intermediate values during SHIFT; only values qualified by out_valid are meaningful.

Optional Feature:
Macro ITER_SHIFTER_ROTL_EN.
- Defined: command LR=1, AL=1 performs rotate-left. The MSB shifted out re-enters at the LSB each step.
- Undefined: LR=1, AL=1 is an ordinary left shift, identical to AL=0.
- Right shifts are unaffected in both builds. Latency and handshake are unchanged.

Test Plan:
1. din=0x96, shamt=3, LR=1, AL=0 -> out_valid 3 cycles after accept; dout=0xB0. Then out_ready=1 -> IDLE, in_ready=1 next cycle.
2. din=0x96, shamt=2, LR=0, AL=0 -> dout=0x25. Repeat with AL=1, shamt=5 -> dout=0xFC (sign fill). Repeat with din=0x76, shamt=7, AL=1 -> dout=0x00.
3. din=0x96, shamt=0, any LR/AL -> out_valid in the cycle after accept; dout=0x96.
4. Case 1 with out_ready=0 for 4 cycles while in_valid=1 and din/shamt toggle -> dout stays 0xB0, out_valid=1, in_ready=0, no new command accepted. Release -> normal completion.
5. Accept din=0x80, shamt=7, LR=0, AL=1. Assert rst_n=0 for one edge after 3 shift edges -> next cycle: in_ready=1, out_valid=0, busy=0, dout=0. A new command then completes correctly.
6. With ITER_SHIFTER_ROTL_EN defined: din=0x96, shamt=3, LR=1, AL=1 -> dout=0xB4. Without the macro, the same stimulus -> dout=0xB0.
